// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: requester, response and shared-ALU signals of the arbiter
interface alu_share_arbiter_if #(parameter int DATA_W = 32);
    logic              req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]        req0_op, req1_op;
    logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic              rsp0_valid, rsp0_ready, rsp0_zero, rsp0_err;
    logic              rsp1_valid, rsp1_ready, rsp1_zero, rsp1_err;
    logic [DATA_W-1:0] rsp0_result, rsp1_result;
    logic [DATA_W-1:0] alu_in1, alu_in2, alu_result;
    logic [3:0]        alu_ctrl;
    logic              alu_zero;
    logic              busy;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b, req1_valid, req1_op, req1_a, req1_b,
        output rsp0_ready, rsp1_ready, alu_result, alu_zero,
        input  req0_ready, req1_ready, rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
        input  rsp1_valid, rsp1_result, rsp1_zero, rsp1_err, alu_in1, alu_in2, alu_ctrl, busy
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, req1_valid, req1_op, req1_a, req1_b,
        input  rsp0_ready, rsp1_ready, alu_result, alu_zero,
        output req0_ready, req1_ready, rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
        output rsp1_valid, rsp1_result, rsp1_zero, rsp1_err, alu_in1, alu_in2, alu_ctrl, busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between two requesters
module alu_share_arbiter #(
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 3
) (
    input logic               gated_clock,
    input logic               reset,
    alu_share_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] MUL_OP  = 4'b0110;
    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);

    state_t            state;
    logic [3:0]        cnt, op_q, op_in;
    logic [DATA_W-1:0] a_q, b_q;
    logic              last, owner;
    logic [DATA_W-1:0] res0, res1;
    logic              zero0, zero1, err0, err1;
    logic              grant0, grant1, op_ok;

    // grant decision: lone requester always wins, collisions go to the one not granted last
    always_comb begin
        grant0 = state == IDLE && bus.req0_valid && (!bus.req1_valid || last);
        grant1 = state == IDLE && bus.req1_valid && (!bus.req0_valid || !last);
        op_in  = grant1 ? bus.req1_op : bus.req0_op;
        op_ok  = op_q <= 4'd8;
    end

    assign bus.req0_ready  = grant0;
    assign bus.req1_ready  = grant1;
    assign bus.rsp0_valid  = state == RESP && !owner;
    assign bus.rsp1_valid  = state == RESP && owner;
    assign bus.rsp0_result = res0;
    assign bus.rsp0_zero   = zero0;
    assign bus.rsp0_err    = err0;
    assign bus.rsp1_result = res1;
    assign bus.rsp1_zero   = zero1;
    assign bus.rsp1_err    = err1;
    assign bus.alu_in1     = a_q;
    assign bus.alu_in2     = b_q;
    assign bus.alu_ctrl    = op_q;
    assign bus.busy        = state != IDLE;

    // accept, execute for the op's latency, then hold the owner's response until consumed
    always_ff @(posedge gated_clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            last  <= 1'b1;
            owner <= 1'b0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            res0  <= '0;
            res1  <= '0;
            zero0 <= 1'b0;
            zero1 <= 1'b0;
            err0  <= 1'b0;
            err1  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (grant0 || grant1) begin
                    owner <= grant1;
                    op_q  <= op_in;
                    a_q   <= grant1 ? bus.req1_a : bus.req0_a;
                    b_q   <= grant1 ? bus.req1_b : bus.req0_b;
                    cnt   <= op_in == MUL_OP ? MUL_CNT : 4'd0;
                    state <= EXEC;
                end
                EXEC: if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end else begin
                    if (owner) begin
                        res1  <= op_ok ? bus.alu_result : '0;
                        zero1 <= op_ok ? bus.alu_zero : 1'b1;
                        err1  <= !op_ok;
                    end else begin
                        res0  <= op_ok ? bus.alu_result : '0;
                        zero0 <= op_ok ? bus.alu_zero : 1'b1;
                        err0  <= !op_ok;
                    end
                    state <= RESP;
                end
                RESP: if (owner ? bus.rsp1_ready : bus.rsp0_ready) begin
                    last  <= owner;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed checks of arbitration, latency, response hold and reset abort
module tb_alu_share_arbiter;
    logic gated_clock = 1'b0;
    logic reset       = 1'b1;
    int   passed      = 0;
    int   total       = 0;
    int   lat;
    bit   flag_a, flag_b, flag_c;

    alu_share_arbiter_if #(.DATA_W(32)) bus ();

    alu_share_arbiter #(.DATA_W(32), .MUL_LAT(3)) dut (
        .gated_clock (gated_clock),
        .reset       (reset),
        .bus         (bus)
    );

    // free-running clock
    always #5 gated_clock = ~gated_clock;

    // reference shared ALU; unsupported codes return a nonzero pattern the arbiter must mask
    always_comb begin
        case (bus.alu_ctrl)
            4'b0000: bus.alu_result = bus.alu_in1 & bus.alu_in2;
            4'b0001: bus.alu_result = bus.alu_in1 | bus.alu_in2;
            4'b0010: bus.alu_result = bus.alu_in1 + bus.alu_in2;
            4'b0011: bus.alu_result = bus.alu_in1 ^ bus.alu_in2;
            4'b0100: bus.alu_result = bus.alu_in1 - bus.alu_in2;
            4'b0101: bus.alu_result = {31'd0, bus.alu_in1 < bus.alu_in2};
            4'b0110: bus.alu_result = bus.alu_in1 * bus.alu_in2;
            4'b0111: bus.alu_result = ~(bus.alu_in1 | bus.alu_in2);
            4'b1000: bus.alu_result = bus.alu_in1 << bus.alu_in2[4:0];
            default: bus.alu_result = 32'hDEAD_BEEF;
        endcase
        bus.alu_zero = bus.alu_result == 32'd0;
    end

    // hard stop in case the sequence ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge gated_clock);
        #1;
    endtask

    task automatic issue(input bit n, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bit ok = 1'b0;
        if (n) begin
            bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            ok = n ? bus.req1_ready : bus.req0_ready;
            tick();
        end
        if (n) bus.req1_valid = 1'b0;
        else bus.req0_valid = 1'b0;
        if (!ok) check("issue_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_rsp(input bit n, output int cycles);
        cycles = 0;
        while (!(n ? bus.rsp1_valid : bus.rsp0_valid) && cycles < 40) begin
            tick();
            cycles++;
        end
        if (cycles >= 40) check("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic consume(input bit n);
        if (n) bus.rsp1_ready = 1'b1;
        else bus.rsp0_ready = 1'b1;
        tick();
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
    endtask

    initial begin
        bus.req0_valid = 0; bus.req0_op = 0; bus.req0_a = 0; bus.req0_b = 0;
        bus.req1_valid = 0; bus.req1_op = 0; bus.req1_a = 0; bus.req1_b = 0;
        bus.rsp0_ready = 0; bus.rsp1_ready = 0;
        repeat (2) tick();
        check("rst_busy", bus.busy, 0);
        check("rst_rsp0_valid", bus.rsp0_valid, 0);
        check("rst_rsp1_valid", bus.rsp1_valid, 0);
        check("rst_alu_ctrl", bus.alu_ctrl, 0);
        check("rst_alu_in1", bus.alu_in1, 0);
        check("rst_rsp0_result", bus.rsp0_result, 0);
        check("rst_rsp1_zero", bus.rsp1_zero, 0);
        reset = 1'b0;

        bus.req0_valid = 1; bus.req0_op = 4'b0001; bus.req0_a = 3; bus.req0_b = 5;
        bus.req1_valid = 1; bus.req1_op = 4'b0001; bus.req1_a = 8; bus.req1_b = 1;
        #1;
        check("pair1_req0_ready", bus.req0_ready, 1);
        check("pair1_req1_ready", bus.req1_ready, 0);
        tick();
        bus.req0_valid = 0;
        check("pair1_busy", bus.busy, 1);
        check("pair1_alu_in1", bus.alu_in1, 3);
        check("pair1_alu_ctrl", bus.alu_ctrl, 1);
        check("exec_req1_ready", bus.req1_ready, 0);
        tick();
        check("pair1_rsp0_valid", bus.rsp0_valid, 1);
        check("pair1_rsp0_result", bus.rsp0_result, 7);
        check("pair1_rsp1_valid", bus.rsp1_valid, 0);
        check("resp_req1_ready", bus.req1_ready, 0);
        consume(0);
        check("pair1_req1_ready_after", bus.req1_ready, 1);
        tick();
        bus.req1_valid = 0;
        tick();
        check("pair1_rsp1_valid", bus.rsp1_valid, 1);
        check("pair1_rsp1_result", bus.rsp1_result, 9);
        check("pair1_rsp0_idle", bus.rsp0_valid, 0);
        consume(1);
        bus.req0_valid = 1; bus.req1_valid = 1;
        #1;
        check("pair2_req0_ready", bus.req0_ready, 1);
        check("pair2_req1_ready", bus.req1_ready, 0);
        bus.req0_valid = 0; bus.req1_valid = 0;

        issue(0, 4'b0010, 9, 6);
        wait_rsp(0, lat);
        check("add_latency", lat, 1);
        check("add_result", bus.rsp0_result, 15);
        check("add_zero", bus.rsp0_zero, 0);
        check("add_err", bus.rsp0_err, 0);
        consume(0);
        bus.req0_valid = 1; bus.req1_valid = 1;
        #1;
        check("pair3_req1_ready", bus.req1_ready, 1);
        check("pair3_req0_ready", bus.req0_ready, 0);
        bus.req0_valid = 0; bus.req1_valid = 0;

        issue(1, 4'b0100, 5, 5);
        wait_rsp(1, lat);
        check("sub_latency", lat, 1);
        check("sub_result", bus.rsp1_result, 0);
        check("sub_zero", bus.rsp1_zero, 1);
        check("sub_rsp0_valid", bus.rsp0_valid, 0);
        check("sub_rsp0_retained", bus.rsp0_result, 15);
        consume(1);

        issue(0, 4'b0110, 7, 6);
        lat = 0;
        flag_a = 1;
        while (!bus.rsp0_valid && lat < 40) begin
            flag_a &= bus.busy;
            tick();
            lat++;
        end
        check("mul_latency", lat, 3);
        check("mul_result", bus.rsp0_result, 42);
        check("mul_busy_exec", flag_a, 1);
        check("mul_busy_resp", bus.busy, 1);
        consume(0);

        issue(0, 4'b0000, 12, 10);
        wait_rsp(0, lat);
        bus.req1_valid = 1; bus.req1_op = 4'b0011; bus.req1_a = 5; bus.req1_b = 3;
        bus.rsp1_ready = 1;
        flag_a = 1; flag_b = 1; flag_c = 1;
        repeat (5) begin
            flag_a &= bus.rsp0_valid && bus.rsp0_result == 32'd8 && !bus.rsp0_zero && !bus.rsp0_err;
            flag_b &= !bus.req1_ready;
            flag_c &= !bus.rsp1_valid;
            tick();
        end
        check("hold_rsp0_stable", flag_a, 1);
        check("hold_req1_ready_low", flag_b, 1);
        check("hold_rsp1_ignored", flag_c, 1);
        bus.rsp1_ready = 0;
        consume(0);
        check("release_req1_ready", bus.req1_ready, 1);
        tick();
        bus.req1_valid = 0;
        check("release_busy", bus.busy, 1);
        wait_rsp(1, lat);
        check("xor_result", bus.rsp1_result, 6);
        consume(1);

        issue(0, 4'b0110, 7, 6);
        tick();
        #2;
        reset = 1;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_rsp0_valid", bus.rsp0_valid, 0);
        check("abort_rsp0_cleared", bus.rsp0_result, 0);
        #3;
        reset = 0;
        flag_a = 1;
        repeat (6) begin
            tick();
            flag_a &= !bus.rsp0_valid && !bus.rsp1_valid && !bus.busy;
        end
        check("abort_no_rsp", flag_a, 1);
        issue(0, 4'b1111, 4, 4);
        wait_rsp(0, lat);
        check("bad_latency", lat, 1);
        check("bad_result", bus.rsp0_result, 0);
        check("bad_zero", bus.rsp0_zero, 1);
        check("bad_err", bus.rsp0_err, 1);
        consume(0);
        check("final_idle", bus.busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, operand/result width.
REQ-002 The block SHALL have parameter MUL_LAT, default 3, EXEC cycles for multiply op 4'b0110 (legal range 1..15).
REQ-003 gated_clock  input  1  clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 reqN_valid  input  1  (N=0,1) requester N presents an op.
REQ-006 reqN_ready  output  1  (N=0,1) op accepted at this edge when high with reqN_valid.
REQ-007 reqN_op  input  4  (N=0,1) ALU control code.
REQ-008 reqN_a, reqN_b  input  DATA_W  (N=0,1) operands.
REQ-009 rspN_valid  output  1  (N=0,1) result available for requester N.
REQ-010 rspN_ready  input  1  (N=0,1) requester N consumes the result.
REQ-011 rspN_result  output  DATA_W, rspN_zero  output  1, rspN_err  output  1  (N=0,1) result, zero flag, unsupported-op flag.
REQ-012 alu_in1, alu_in2  output  DATA_W  operands to the shared ALU.
REQ-013 alu_ctrl  output  4  control code to the shared ALU.
REQ-014 alu_result  input  DATA_W, alu_zero  input  1  combinational ALU response.
REQ-015 busy  output  1  high whenever the state is not IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, EXEC, RESP.
REQ-017 IDLE: if exactly one reqN_valid is high, reqN_ready SHALL be driven high for it; with both valid, only the requester not granted last SHALL see ready high.
REQ-018 reqN_ready SHALL be low in EXEC and RESP; ready SHALL depend only on state, pointer and reqN_valid.
REQ-019 On accept: op, a, b latched into operand registers, owner recorded, state -> EXEC, cycle counter loaded with MUL_LAT-1 for op 4'b0110, else 0.
REQ-020 alu_in1/alu_in2/alu_ctrl SHALL be driven from the operand registers in all states.
REQ-021 EXEC with counter 0: alu_result/alu_zero captured into the owner's response registers, state -> RESP; counter nonzero: decrement, stay in EXEC.
REQ-022 Supported ops: 0000, 0001, 0010, 0011, 0100, 0101, 0110, 0111, 1000; any other op SHALL take one EXEC cycle and return result 0, zero 1, err 1.
REQ-023 Latency: non-multiply accepted at edge k SHALL give rsp_valid high from edge k+1; multiply from edge k+MUL_LAT.
REQ-024 RESP: only the owner's rspN_valid SHALL be high; result/zero/err SHALL hold stable until rspN_ready is sampled high.
REQ-025 RESP with owner's rspN_ready high: state -> IDLE, last-grant pointer := owner; new request accepted no earlier than the following cycle.
REQ-026 rspN_ready of the non-owner SHALL be ignored; reqN_valid changes in EXEC/RESP SHALL have no effect.
REQ-027 Round-robin SHALL apply only on simultaneous requests; a lone requester SHALL be granted back-to-back.
REQ-028 Response registers of the non-owner SHALL retain their previous values.

Reset
REQ-029 Reset SHALL force IDLE, counter 0, pointer = "req1 granted last" (req0 wins first collision), operand registers 0, alu_ctrl 0, all rsp registers 0, all rspN_valid 0, busy 0.
REQ-030 Reset asserted in EXEC or RESP SHALL abort the op with no response ever delivered for it.
REQ-031 After reset deassertion the first rising edge with a valid request SHALL accept it.

Verification
REQ-032 req0 op 0010 a=9 b=6 -> req0_ready high in IDLE, rsp0_valid one cycle after accept, rsp0_result=15, zero=0, err=0.
REQ-033 req1 op 0100 a=5 b=5 -> rsp1_result=0, rsp1_zero=1; rsp0_valid stays 0.
REQ-034 Both valid after reset (ops 0001) -> req0 served first, then req1; next simultaneous pair -> req0 again (pointer on req1).
REQ-035 req0 op 0110 a=7 b=6, MUL_LAT=3 -> rsp0_valid exactly 3 cycles after accept, result=42, busy high throughout.
REQ-036 rsp0_ready held low 5 cycles with req1_valid high -> rsp0 outputs stable, req1_ready 0; on release req1 accepted next cycle.
REQ-037 Reset pulse during EXEC of multiply -> busy 0, no rsp_valid; subsequent op 1111 -> result 0, zero 1, err 1.
